imm_extend_pipe: RTL and testbench

//   Parametrised, pipelined immediate-to-word unit for the MMIPS decode/execute path.

---
 rtl/imm_extend_pipe.sv | 114 +++++++++++
 tb/tb_imm_extend_pipe.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
// Two-stage immediate extension unit: zero/sign/upper/branch-offset widening with valid/ready flow control.
// Optional IMM_PIPE_BASE_ADD_EN adds a base operand summed in stage 2 with carry-out.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
`ifdef IMM_PIPE_BASE_ADD_EN
  input  logic [OUT_W-1:0] in_base,
  output logic             out_carry,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_word,
  output logic             out_neg
);

  function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] imm,
                                               input logic [1:0]      mode);
    logic signed [OUT_W-1:0] sext;
    sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    case (mode)
      2'b00:   extend = {{(OUT_W-IN_W){1'b0}}, imm};
      2'b01:   extend = sext;
      2'b10:   extend = {imm, {(OUT_W-IN_W){1'b0}}};
      default: extend = sext <<< SHIFT;
    endcase
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic [OUT_W-1:0] s1_ext_q,   s1_ext_d;
  logic             s2_valid_q, s2_valid_d;
  logic [OUT_W-1:0] s2_word_q,  s2_word_d;
  logic             s2_adv, s1_adv, s1_load, s2_load;
`ifdef IMM_PIPE_BASE_ADD_EN
  logic [OUT_W-1:0] s1_base_q,  s1_base_d;
  logic             s2_carry_q, s2_carry_d;
  logic [OUT_W:0]   sum;
`endif

  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = s1_adv && !flush;
    s1_load  = in_valid && in_ready;
    // flush freezes data registers; only the valid bits are cleared
    s2_load  = s2_adv && s1_valid_q && !flush;

    s1_valid_d = s1_valid_q;
    s1_ext_d   = s1_ext_q;
    s2_valid_d = s2_valid_q;
    s2_word_d  = s2_word_q;

    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s1_adv) s1_valid_d = in_valid;
      if (s2_adv) s2_valid_d = s1_valid_q;
    end
    if (s1_load) s1_ext_d = extend(in_imm, in_mode);

`ifdef IMM_PIPE_BASE_ADD_EN
    s1_base_d  = s1_base_q;
    s2_carry_d = s2_carry_q;
    sum        = {1'b0, s1_base_q} + {1'b0, s1_ext_q};
    if (s1_load) s1_base_d = in_base;
    if (s2_load) begin
      s2_word_d  = sum[OUT_W-1:0];
      s2_carry_d = sum[OUT_W];
    end
`else
    if (s2_load) s2_word_d = s1_ext_q;
`endif
  end

  // stage 1 / stage 2 register boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_ext_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_word_q  <= '0;
`ifdef IMM_PIPE_BASE_ADD_EN
      s1_base_q  <= '0;
      s2_carry_q <= 1'b0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_ext_q   <= s1_ext_d;
      s2_valid_q <= s2_valid_d;
      s2_word_q  <= s2_word_d;
`ifdef IMM_PIPE_BASE_ADD_EN
      s1_base_q  <= s1_base_d;
      s2_carry_q <= s2_carry_d;
`endif
    end
  end

  assign out_valid = s2_valid_q;
  assign out_word  = s2_word_q;
  assign out_neg   = s2_word_q[OUT_W-1];
`ifdef IMM_PIPE_BASE_ADD_EN
  assign out_carry = s2_carry_q;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: driver pushes expected words, monitor pops on each output transfer.
module tb_imm_extend_pipe;
  localparam int IN_W  = 16;
  localparam int OUT_W = 32;
  localparam int SHIFT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_imm = '0;
  logic [1:0]  in_mode = '0;
  logic [31:0] in_base = '0;
  logic        out_carry;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_word;
  logic        out_neg;

  logic        s_valid = 1'b0;
  logic        s_in_ready;
  logic [11:0] s_imm = '0;
  logic [1:0]  s_mode = '0;
  logic [19:0] s_base = '0;
  logic        s_carry;
  logic        s_out_valid;
  logic [19:0] s_word;
  logic        s_neg;

  imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
`ifdef IMM_PIPE_BASE_ADD_EN
    .in_base(in_base), .out_carry(out_carry),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word), .out_neg(out_neg)
  );

  imm_extend_pipe #(.IN_W(12), .OUT_W(20), .SHIFT(1)) u_small (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(s_valid), .in_ready(s_in_ready), .in_imm(s_imm), .in_mode(s_mode),
`ifdef IMM_PIPE_BASE_ADD_EN
    .in_base(s_base), .out_carry(s_carry),
`endif
    .out_valid(s_out_valid), .out_ready(1'b1), .out_word(s_word), .out_neg(s_neg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic        carry;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          rand_rdy = 1'b0;
  bit          held_v = 1'b0;
  logic [31:0] held_w;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: signed/unsigned value of the immediate scaled by a power of two, mod 2^OUT_W
  function automatic longint model_ext(input logic [15:0] imm, input logic [1:0] mode);
    longint v;
    v = longint'(imm);
    if ((mode == 2'b01 || mode == 2'b11) && v >= (64'sd1 << (IN_W-1)))
      v = v - (64'sd1 << IN_W);
    case (mode)
      2'b10:   v = v * (64'sd1 << (OUT_W-IN_W));
      2'b11:   v = v * (64'sd1 << SHIFT);
      default: v = v;
    endcase
    return v & ((64'sd1 << OUT_W) - 1);
  endfunction

  task automatic send(input logic [15:0] imm, input logic [1:0] mode, input logic [31:0] base,
                      input logic [31:0] ew, input logic ec, input bit lat);
    int   guard;
    exp_t e;
    guard    = 0;
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = mode;
    in_base  = base;
    @(negedge clk);
    if (lat) check("in_ready_unstalled", in_ready, 1);
    while (!in_ready && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
    end else begin
      e.word  = ew;
      e.carry = ec;
      e.cyc   = cyc;
      e.lat   = lat;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [15:0] imm, input logic [1:0] mode,
                            input logic [31:0] base, input bit lat);
    longint ext;
    longint tot;
    logic [63:0] t;
    ext = model_ext(imm, mode);
`ifdef IMM_PIPE_BASE_ADD_EN
    tot = ext + longint'(base);
`else
    tot = ext;
`endif
    t = tot;
    send(imm, mode, base, t[31:0], t[32], lat);
  endtask

  // Monitor: pops on every output transfer, tracks stall stability, drops queue on flush
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (held_v && out_valid) check("stall_hold", out_word, held_w);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {32'h0, out_word}, 64'hDEAD_0000_0000_0000);
        end else begin
          e = exp_q.pop_front();
          check("out_word", out_word, e.word);
          check("out_neg", out_neg, e.word[31]);
`ifdef IMM_PIPE_BASE_ADD_EN
          check("out_carry", out_carry, e.carry);
`endif
          if (e.lat) check("latency", cyc - e.cyc, 2);
        end
      end
      held_v = out_valid && !out_ready;
      held_w = out_word;
      if (flush) exp_q.delete();
    end else begin
      held_v = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    // reset state
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_word", out_word, 0);
    check("rst_out_neg", out_neg, 0);
`ifdef IMM_PIPE_BASE_ADD_EN
    check("rst_out_carry", out_carry, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // small parameter set: 12->20 bits, shift 1
    s_valid = 1'b1; s_imm = 12'h800; s_mode = 2'b11;
    @(posedge clk); #1; s_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("small_valid", s_out_valid, 1);
    check("small_word", s_word, 20'hFF000);
    check("small_neg", s_neg, 1);
    @(posedge clk); #1;

    // mode sweep
    out_ready = 1'b1;
    send(16'h8001, 2'b00, 32'h0, 32'h00008001, 1'b0, 1);
    send(16'h8001, 2'b01, 32'h0, 32'hFFFF8001, 1'b0, 1);
    send(16'h8001, 2'b10, 32'h0, 32'h80010000, 1'b0, 1);
    send(16'h8001, 2'b11, 32'h0, 32'hFFFE0004, 1'b0, 1);
`ifdef IMM_PIPE_BASE_ADD_EN
    send(16'h0010, 2'b01, 32'hFFFFFFF0, 32'h0, 1'b1, 1);
`endif
    repeat (3) @(posedge clk);
    #1;

    // back-to-back 8 words
    for (int i = 0; i < 8; i++)
      send_model(16'($urandom), 2'(i), 32'h0, 1);
    repeat (3) @(posedge clk);
    #1;

    // backpressure: 3 words with out_ready low
    out_ready = 1'b0;
    send(16'h1234, 2'b00, 32'h0, 32'h00001234, 1'b0, 0);
    send(16'h00FF, 2'b10, 32'h0, 32'h00FF0000, 1'b0, 0);
    in_valid = 1'b1; in_imm = 16'hFFFF; in_mode = 2'b01; in_base = 32'h0;
    @(negedge clk);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    @(posedge clk); #1;
    check("bp_in_ready_still_low", in_ready, 0);
    out_ready = 1'b1;
    send(16'hFFFF, 2'b01, 32'h0, 32'hFFFFFFFF, 1'b0, 0);
    repeat (4) @(posedge clk);
    #1;

    // flush with both stages full and in_valid high
    out_ready = 1'b0;
    send_model(16'h4444, 2'b01, 32'h0, 0);
    send_model(16'h5555, 2'b11, 32'h0, 0);
    in_valid = 1'b1; in_imm = 16'h6666; flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("flush_nothing_queued", exp_q.size(), 0);

    // asynchronous reset mid-stream
    send_model(16'h7ABC, 2'b10, 32'h0, 0);
    send_model(16'h8ABC, 2'b01, 32'h0, 0);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_word", out_word, 0);
    exp_q.delete();
    #1;
    rst_n = 1'b1;
    #1;
    check("arst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    send_model(16'h0ACE, 2'b00, 32'h0, 1);
    send_model(16'hFACE, 2'b11, 32'h0, 1);
    repeat (3) @(posedge clk);
    #1;

    // randomized traffic with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end else begin
        send_model(16'($urandom), 2'($urandom), $urandom, 0);
      end
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 64) begin
      @(posedge clk);
      guard++;
    end
    check("drain_empty", exp_q.size(), 0);
    @(negedge clk);
    check("final_idle", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
